// File: rtl/regfile_wb_sequencer_pkg.sv
// Shared widths, write-source encoding and the default-width writeback entry layout
// for the register-file write-side sequencer.
package regfile_wb_sequencer_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_ALU  = 2'd1,
        WB_SRC_FIFO = 2'd2
    } wb_src_e;

endpackage

// File: rtl/regfile_wb_sequencer_wb_fifo.sv
// Synchronous FIFO with same-cycle push+pop; head is read combinationally.
// Push is ignored when full and pop is ignored when empty.
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/regfile_wb_sequencer.sv
// Merges ALU and long-latency results into one registered register-file write port
// (latency 1) and tracks per-register busy bits for decode hazard detection.
module regfile_wb_sequencer
    import regfile_wb_sequencer_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Alu_valid,
    output logic              Alu_ready,
    input  logic [ADDR_W-1:0] Alu_rd,
    input  logic [DATA_W-1:0] Alu_data,
    input  logic              Ld_valid,
    output logic              Ld_ready,
    input  logic [ADDR_W-1:0] Ld_rd,
    input  logic [DATA_W-1:0] Ld_data,
    input  logic              Issue_valid,
    input  logic [ADDR_W-1:0] Issue_rd,
    input  logic [ADDR_W-1:0] Src_a,
    input  logic [ADDR_W-1:0] Src_b,
    output logic              Hazard,
    output logic              WE,
    output logic [ADDR_W-1:0] Rw,
    output logic [DATA_W-1:0] busW
);

    localparam int NREG  = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            push_ent, head_ent, sel_ent;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop, has_room;
    logic [CNT_W-1:0]  fifo_count;
    wb_src_e           src;

    logic [NREG-1:0]   busy_q, busy_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] rw_q, rw_d;
    logic [DATA_W-1:0] busw_q, busw_d;

    assign has_room  = (fifo_count < CNT_W'(DEPTH));
    assign Ld_ready  = !Reset && has_room;
    assign Alu_ready = !Reset && has_room;
    assign fifo_push = Ld_valid && Ld_ready;
    assign fifo_pop  = (src == WB_SRC_FIFO);
    assign push_ent  = '{rd: Ld_rd, data: Ld_data};

    wb_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (Clk),
        .rst_i      (Reset),
        .push_i     (fifo_push),
        .push_dat_i (push_ent),
        .pop_i      (fifo_pop),
        .head_dat_o (head_ent),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    // A full FIFO must drain before the ALU may write, otherwise loads could starve.
    always_comb begin
        src     = WB_SRC_NONE;
        sel_ent = head_ent;
        if (fifo_full) begin
            src = WB_SRC_FIFO;
        end else if (Alu_valid) begin
            src     = WB_SRC_ALU;
            sel_ent = '{rd: Alu_rd, data: Alu_data};
        end else if (!fifo_empty) begin
            src = WB_SRC_FIFO;
        end
    end

    always_comb begin
        we_d   = 1'b0;
        rw_d   = rw_q;
        busw_d = busw_q;
        if (src != WB_SRC_NONE) begin
            we_d   = (sel_ent.rd != '0);
            rw_d   = sel_ent.rd;
            busw_d = sel_ent.data;
        end
    end

    // Clear applied before set so a re-issue retiring on the same edge stays busy.
    always_comb begin
        busy_d = busy_q;
        if (src == WB_SRC_FIFO) begin
            busy_d[head_ent.rd] = 1'b0;
        end
        if (Issue_valid) begin
            busy_d[Issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            busy_q <= '0;
            we_q   <= 1'b0;
            rw_q   <= '0;
            busw_q <= '0;
        end else begin
            busy_q <= busy_d;
            we_q   <= we_d;
            rw_q   <= rw_d;
            busw_q <= busw_d;
        end
    end

    assign Hazard = busy_q[Src_a] | busy_q[Src_b];
    assign WE     = we_q;
    assign Rw     = rw_q;
    assign busW   = busw_q;

    // Re-issuing to a busy register is only legal when its old result retires this cycle.
    a_no_waw: assert property (@(posedge Clk) disable iff (Reset)
        (Issue_valid && Issue_rd != '0) |->
            (!busy_q[Issue_rd] || (src == WB_SRC_FIFO && head_ent.rd == Issue_rd)));

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Directed bench: stimulus queues expected register-file writes, a negedge monitor
// pops and compares them whenever WE is asserted.
module tb_regfile_wb_sequencer;
    import regfile_wb_sequencer_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Alu_valid = 1'b0, Ld_valid = 1'b0, Issue_valid = 1'b0;
    logic        Alu_ready, Ld_ready, Hazard, WE;
    logic [4:0]  Alu_rd = '0, Ld_rd = '0, Issue_rd = '0, Src_a = '0, Src_b = '0, Rw;
    logic [31:0] Alu_data = '0, Ld_data = '0, busW;

    int n_vec = 0;
    int n_err = 0;
    wb_entry_t exp_q[$];

    regfile_wb_sequencer #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) dut (
        .Clk(Clk), .Reset(Reset),
        .Alu_valid(Alu_valid), .Alu_ready(Alu_ready), .Alu_rd(Alu_rd), .Alu_data(Alu_data),
        .Ld_valid(Ld_valid), .Ld_ready(Ld_ready), .Ld_rd(Ld_rd), .Ld_data(Ld_data),
        .Issue_valid(Issue_valid), .Issue_rd(Issue_rd),
        .Src_a(Src_a), .Src_b(Src_b), .Hazard(Hazard),
        .WE(WE), .Rw(Rw), .busW(busW)
    );

    always #5 Clk = ~Clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endfunction

    function automatic void expect_wr(logic [4:0] rd, logic [31:0] data);
        wb_entry_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endfunction

    always @(negedge Clk) begin
        if (WE === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got Rw=%0d busW=%h, required no write", Rw, busW);
            end else begin
                wb_entry_t e;
                e = exp_q.pop_front();
                check("wb_rw", {27'b0, Rw}, {27'b0, e.rd});
                check("wb_busW", busW, e.data);
            end
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic drain(string name);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge Clk);
        #1;
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int  ai, li;
        logic afire, lfire;

        // Reset with a load waiting: nothing may be accepted.
        Ld_valid = 1'b1; Ld_rd = 5'd7; Ld_data = 32'h7777_7777; Src_a = 5'd8;
        repeat (2) cyc();
        #1;
        check("rst_we", WE, 0);
        check("rst_rw", Rw, 0);
        check("rst_busW", busW, 0);
        check("rst_ld_ready", Ld_ready, 0);
        check("rst_alu_ready", Alu_ready, 0);
        check("rst_hazard", Hazard, 0);
        Reset = 1'b0; Ld_valid = 1'b0; Src_a = 5'd0;
        cyc();
        check("post_rst_ld_ready", Ld_ready, 1);
        check("post_rst_alu_ready", Alu_ready, 1);
        check("post_rst_we", WE, 0);

        // Single ALU write.
        Alu_valid = 1'b1; Alu_rd = 5'd5; Alu_data = 32'hDEAD_BEEF;
        expect_wr(5'd5, 32'hDEAD_BEEF);
        cyc();
        Alu_valid = 1'b0;
        check("alu_we_set", WE, 1);
        cyc();
        check("alu_we_drop", WE, 0);

        // Scoreboard set by issue, cleared by the load pop.
        Issue_valid = 1'b1; Issue_rd = 5'd8;
        cyc();
        Issue_valid = 1'b0; Src_a = 5'd8;
        #1 check("sb_hazard_set", Hazard, 1);
        Ld_valid = 1'b1; Ld_rd = 5'd8; Ld_data = 32'h0000_1234;
        expect_wr(5'd8, 32'h0000_1234);
        cyc();
        Ld_valid = 1'b0;
        check("sb_hazard_queued", Hazard, 1);
        cyc();
        check("sb_hazard_clear", Hazard, 0);
        check("sb_we", WE, 1);
        Src_a = 5'd0;
        drain("sb_drain");

        // ALU streaming while four loads fill the FIFO; order derived from priority rules.
        expect_wr(5'd1, 32'hA000_0001);
        expect_wr(5'd2, 32'hA000_0002);
        expect_wr(5'd3, 32'hA000_0003);
        expect_wr(5'd4, 32'hA000_0004);
        expect_wr(5'd10, 32'hB000_000A);
        expect_wr(5'd5, 32'hA000_0005);
        expect_wr(5'd11, 32'hB000_000B);
        expect_wr(5'd12, 32'hB000_000C);
        expect_wr(5'd13, 32'hB000_000D);
        ai = 1; li = 10;
        for (int c = 0; c < 30 && (ai <= 5 || li <= 13); c++) begin
            Alu_valid = (ai <= 5);  Alu_rd = 5'(ai); Alu_data = 32'hA000_0000 + 32'(ai);
            Ld_valid  = (li <= 13); Ld_rd  = 5'(li); Ld_data  = 32'hB000_0000 + 32'(li);
            #1;
            if (c == 4) begin
                check("full_alu_ready", Alu_ready, 0);
                check("full_ld_ready", Ld_ready, 0);
                check("full_alu_held_rd", {27'b0, Alu_rd}, 32'd5);
            end
            if (c == 5) check("after_pop_alu_ready", Alu_ready, 1);
            afire = Alu_valid && Alu_ready;
            lfire = Ld_valid && Ld_ready;
            cyc();
            if (afire) ai++;
            if (lfire) li++;
        end
        Alu_valid = 1'b0; Ld_valid = 1'b0;
        check("stream_alu_all_sent", ai, 6);
        check("stream_ld_all_sent", li, 14);
        drain("stream_drain");

        // rd==0 results are consumed silently; Rw/busW still follow.
        Alu_valid = 1'b1; Alu_rd = 5'd0; Alu_data = 32'h0000_0A0A;
        cyc();
        Alu_valid = 1'b0;
        check("rd0_alu_we", WE, 0);
        check("rd0_alu_busW", busW, 32'h0000_0A0A);
        check("rd0_alu_rw", Rw, 0);
        Ld_valid = 1'b1; Ld_rd = 5'd0; Ld_data = 32'h0000_0B0B;
        cyc();
        Ld_valid = 1'b0;
        cyc();
        check("rd0_ld_we", WE, 0);
        check("rd0_ld_busW", busW, 32'h0000_0B0B);
        Issue_valid = 1'b1; Issue_rd = 5'd0;
        cyc();
        Issue_valid = 1'b0;
        check("rd0_hazard", Hazard, 0);

        // Re-issue on the edge the old result retires: set wins.
        Issue_valid = 1'b1; Issue_rd = 5'd3;
        cyc();
        Issue_valid = 1'b0; Src_b = 5'd3;
        #1 check("ss_hazard_set", Hazard, 1);
        Ld_valid = 1'b1; Ld_rd = 5'd3; Ld_data = 32'h0000_3333;
        expect_wr(5'd3, 32'h0000_3333);
        cyc();
        Ld_valid = 1'b0; Issue_valid = 1'b1; Issue_rd = 5'd3;
        cyc();
        Issue_valid = 1'b0;
        check("ss_hazard_kept", Hazard, 1);
        drain("ss_drain");
        check("ss_hazard_after", Hazard, 1);

        // Reset mid-operation drops a queued load and all busy bits.
        Issue_valid = 1'b1; Issue_rd = 5'd9;
        cyc();
        Issue_valid = 1'b0;
        Ld_valid = 1'b1; Ld_rd = 5'd9; Ld_data = 32'h0000_9999;
        Alu_valid = 1'b1; Alu_rd = 5'd20; Alu_data = 32'hA000_0014;
        expect_wr(5'd20, 32'hA000_0014);
        cyc();
        Ld_valid = 1'b0; Alu_valid = 1'b0; Reset = 1'b1;
        #1 check("mid_rst_ld_ready", Ld_ready, 0);
        cyc();
        Reset = 1'b0; Src_a = 5'd9; Src_b = 5'd3;
        #1;
        check("mid_rst_hazard", Hazard, 0);
        check("mid_rst_we", WE, 0);
        repeat (3) cyc();
        check("mid_rst_no_write", WE, 0);
        drain("final_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
